// File: rtl/convolution_processor_accumulator.sv
// Purpose: pair-add / saturating multi-term accumulator for convolution partial sums.
// Latency: 1 cycle from accepted beat (pair add or closing term) to out_valid.
// Backpressure: single output register; in_ready = !out_valid || out_ready, so beats stall while a result waits.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   in_valid / in_ready      input handshake; beat taken when both high
//   mode                     0 = pair add (A+B straight out), 1 = accumulate
//   in_start / in_last       accumulate framing: clear before term / emit after term
//   re_A, re_B               signed DATA_WIDTH operands
//   out_valid / out_ready    output handshake
//   re_out, ovf, term_cnt    signed result, saturation flag, number of terms summed
module convolution_processor_accumulator #(
    parameter int DATA_WIDTH = 22,
    parameter int ACC_WIDTH  = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         mode,
    input  logic                         in_start,
    input  logic                         in_last,
    input  logic signed [DATA_WIDTH-1:0] re_A,
    input  logic signed [DATA_WIDTH-1:0] re_B,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [ACC_WIDTH-1:0]  re_out,
    output logic                         ovf,
    output logic        [CNT_WIDTH-1:0]  term_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic                   r_ovf_sticky;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic                   r_out_valid;
    logic [ACC_WIDTH-1:0]   r_out;
    logic                   r_ovf;
    logic [CNT_WIDTH-1:0]   r_term_cnt;

    logic                   w_accept;
    logic                   w_fresh;
    logic [ACC_WIDTH:0]     w_a_ext;
    logic [ACC_WIDTH:0]     w_b_ext;
    logic [ACC_WIDTH:0]     w_term;
    logic [ACC_WIDTH:0]     w_base;
    logic [ACC_WIDTH:0]     w_sum;
    logic                   w_clamp;
    logic [ACC_WIDTH-1:0]   w_acc_next;
    logic                   w_ovf_next;
    logic [CNT_WIDTH-1:0]   w_cnt_next;

    assign in_ready  = !r_out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;

    // Operands are widened one bit past the accumulator so that base+term
    // can never wrap; the top two bits then tell us whether to clamp.
    assign w_a_ext = {{(ACC_WIDTH+1-DATA_WIDTH){re_A[DATA_WIDTH-1]}}, re_A};
    assign w_b_ext = {{(ACC_WIDTH+1-DATA_WIDTH){re_B[DATA_WIDTH-1]}}, re_B};
    assign w_term  = w_a_ext + w_b_ext;

    // A sum restarts on an explicit start or whenever no sum is open.
    assign w_fresh = in_start || (r_state == IDLE);
    assign w_base  = w_fresh ? '0 : {r_acc[ACC_WIDTH-1], r_acc};
    assign w_sum   = w_base + w_term;
    assign w_clamp = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];

    assign w_acc_next = w_clamp ? (w_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX)
                                : w_sum[ACC_WIDTH-1:0];
    assign w_ovf_next = (!w_fresh && r_ovf_sticky) || w_clamp;
    assign w_cnt_next = w_fresh ? CNT_ONE
                      : ((r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1);

    // Only accumulate beats move the FSM; pair adds leave it untouched.
    always_comb begin
        w_state_next = r_state;
        if (w_accept && mode) begin
            w_state_next = in_last ? IDLE : ACC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc        <= '0;
            r_ovf_sticky <= 1'b0;
            r_cnt        <= '0;
            r_out_valid  <= 1'b0;
            r_out        <= '0;
            r_ovf        <= 1'b0;
            r_term_cnt   <= '0;
        end else begin
            if (w_accept && mode) begin
                r_acc        <= w_acc_next;
                r_ovf_sticky <= w_ovf_next;
                r_cnt        <= w_cnt_next;
            end
            if (w_accept && (!mode || in_last)) begin
                r_out_valid <= 1'b1;
                r_out       <= mode ? w_acc_next : w_term[ACC_WIDTH-1:0];
                r_ovf       <= mode ? w_ovf_next : 1'b0;
                r_term_cnt  <= mode ? w_cnt_next : CNT_ONE;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign re_out    = r_out;
    assign ovf       = r_ovf;
    assign term_cnt  = r_term_cnt;

endmodule

// File: tb/tb_convolution_processor_accumulator.sv
module tb_convolution_processor_accumulator;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              mode = 1'b0;
    logic              in_start = 1'b0;
    logic              in_last = 1'b0;
    logic signed [7:0] re_A = '0;
    logic signed [7:0] re_B = '0;
    logic              out_ready = 1'b1;

    logic              in_ready;
    logic              out_valid;
    logic signed [9:0] re_out;
    logic              ovf;
    logic [3:0]        term_cnt;

    logic              in_ready2;
    logic              out_valid2;
    logic signed [9:0] re_out2;
    logic              ovf2;
    logic [1:0]        term_cnt2;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    convolution_processor_accumulator #(
        .DATA_WIDTH(8), .ACC_WIDTH(10), .CNT_WIDTH(4)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .in_start(in_start), .in_last(in_last),
        .re_A(re_A), .re_B(re_B), .out_valid(out_valid), .out_ready(out_ready),
        .re_out(re_out), .ovf(ovf), .term_cnt(term_cnt)
    );

    convolution_processor_accumulator #(
        .DATA_WIDTH(8), .ACC_WIDTH(10), .CNT_WIDTH(2)
    ) dut_cnt2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .mode(mode), .in_start(in_start), .in_last(in_last),
        .re_A(re_A), .re_B(re_B), .out_valid(out_valid2), .out_ready(out_ready),
        .re_out(re_out2), .ovf(ovf2), .term_cnt(term_cnt2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic m, input logic s, input logic l,
                         input logic signed [7:0] a, input logic signed [7:0] b);
        in_valid = v;
        mode     = m;
        in_start = s;
        in_last  = l;
        re_A     = a;
        re_B     = b;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'sd0, 8'sd0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        step();
        rst = 1'b0;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0d exp 0", out_valid); else pass_cnt++;
        total_cnt++; if (re_out !== 10'sd0) $display("FAIL reset_re_out got %0d exp 0", re_out); else pass_cnt++;
        total_cnt++; if (ovf !== 1'b0) $display("FAIL reset_ovf got %0d exp 0", ovf); else pass_cnt++;
        total_cnt++; if (term_cnt !== 4'd0) $display("FAIL reset_term_cnt got %0d exp 0", term_cnt); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0d exp 1", in_ready); else pass_cnt++;
    endtask

    task automatic test_pair_add();
        out_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'sh7F, 8'sh01);
        step();
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL pair_out_valid got %0d exp 1", out_valid); else pass_cnt++;
        total_cnt++; if (re_out !== 10'sd128) $display("FAIL pair_re_out got %0d exp 128", re_out); else pass_cnt++;
        total_cnt++; if (ovf !== 1'b0) $display("FAIL pair_ovf got %0d exp 0", ovf); else pass_cnt++;
        total_cnt++; if (term_cnt !== 4'd1) $display("FAIL pair_term_cnt got %0d exp 1", term_cnt); else pass_cnt++;
        drive(1'b1, 1'b0, 1'b0, 1'b0, -8'sd128, -8'sd128);
        step();
        total_cnt++; if (re_out !== -10'sd256) $display("FAIL pair_neg_re_out got %0d exp -256", re_out); else pass_cnt++;
        idle();
        step();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL pair_drain_out_valid got %0d exp 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_accumulate();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'sd10, 8'sd5);
        step();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL acc_t1_out_valid got %0d exp 0", out_valid); else pass_cnt++;
        drive(1'b1, 1'b1, 1'b0, 1'b0, -8'sd3, 8'sd0);
        step();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL acc_t2_out_valid got %0d exp 0", out_valid); else pass_cnt++;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 8'sd1, 8'sd1);
        step();
        idle();
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL acc_out_valid got %0d exp 1", out_valid); else pass_cnt++;
        total_cnt++; if (re_out !== 10'sd14) $display("FAIL acc_re_out got %0d exp 14", re_out); else pass_cnt++;
        total_cnt++; if (term_cnt !== 4'd3) $display("FAIL acc_term_cnt got %0d exp 3", term_cnt); else pass_cnt++;
        total_cnt++; if (ovf !== 1'b0) $display("FAIL acc_ovf got %0d exp 0", ovf); else pass_cnt++;
        step();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL acc_one_cycle got %0d exp 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, (i == 0), (i == 4), 8'sd127, 8'sd127);
            step();
        end
        idle();
        total_cnt++; if (re_out !== 10'sd511) $display("FAIL sat_re_out got %0d exp 511", re_out); else pass_cnt++;
        total_cnt++; if (ovf !== 1'b1) $display("FAIL sat_ovf got %0d exp 1", ovf); else pass_cnt++;
        total_cnt++; if (term_cnt !== 4'd5) $display("FAIL sat_term_cnt got %0d exp 5", term_cnt); else pass_cnt++;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'sd1, 8'sd1);
        step();
        total_cnt++; if (re_out !== 10'sd2) $display("FAIL sat_next_re_out got %0d exp 2", re_out); else pass_cnt++;
        total_cnt++; if (ovf !== 1'b0) $display("FAIL sat_next_ovf got %0d exp 0", ovf); else pass_cnt++;
        total_cnt++; if (term_cnt !== 4'd1) $display("FAIL sat_next_term_cnt got %0d exp 1", term_cnt); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, (i == 0), (i == 2), -8'sd128, -8'sd128);
            step();
        end
        idle();
        total_cnt++; if (re_out !== -10'sd512) $display("FAIL sat_neg_re_out got %0d exp -512", re_out); else pass_cnt++;
        total_cnt++; if (ovf !== 1'b1) $display("FAIL sat_neg_ovf got %0d exp 1", ovf); else pass_cnt++;
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'sd3, 8'sd4);
        step();
        total_cnt++; if (re_out !== 10'sd7) $display("FAIL bp_first_re_out got %0d exp 7", re_out); else pass_cnt++;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'sd1, 8'sd2);
        for (int i = 0; i < 5; i++) begin
            total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready cyc %0d got %0d exp 0", i, in_ready); else pass_cnt++;
            step();
            total_cnt++; if (re_out !== 10'sd7) $display("FAIL bp_hold_re_out cyc %0d got %0d exp 7", i, re_out); else pass_cnt++;
            total_cnt++; if (out_valid !== 1'b1) $display("FAIL bp_hold_valid cyc %0d got %0d exp 1", i, out_valid); else pass_cnt++;
        end
        out_ready = 1'b1;
        #1;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_release_in_ready got %0d exp 1", in_ready); else pass_cnt++;
        step();
        idle();
        total_cnt++; if (re_out !== 10'sd3) $display("FAIL bp_next_re_out got %0d exp 3", re_out); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL bp_next_valid got %0d exp 1", out_valid); else pass_cnt++;
        step();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_drain_valid got %0d exp 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 8'(i), 8'(i));
            step();
            total_cnt++; if (out_valid !== 1'b1) $display("FAIL b2b_valid beat %0d got %0d exp 1", i, out_valid); else pass_cnt++;
            total_cnt++; if (re_out !== 10'(2 * i)) $display("FAIL b2b_re_out beat %0d got %0d exp %0d", i, re_out, 2 * i); else pass_cnt++;
        end
        idle();
        step();
    endtask

    task automatic test_reset_mid_sum();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'sd1, 8'sd1);
        step();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'sd2, 8'sd2);
        step();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total_cnt++; if (term_cnt !== 4'd0) $display("FAIL mid_rst_term_cnt got %0d exp 0", term_cnt); else pass_cnt++;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 8'sd4, 8'sd4);
        step();
        idle();
        total_cnt++; if (re_out !== 10'sd8) $display("FAIL mid_rst_re_out got %0d exp 8", re_out); else pass_cnt++;
        total_cnt++; if (term_cnt !== 4'd1) $display("FAIL mid_rst_term_cnt_after got %0d exp 1", term_cnt); else pass_cnt++;
        step();
    endtask

    task automatic test_cnt_saturation();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, (i == 0), (i == 4), 8'sd0, 8'sd1);
            step();
        end
        idle();
        total_cnt++; if (re_out2 !== 10'sd5) $display("FAIL cnt2_re_out got %0d exp 5", re_out2); else pass_cnt++;
        total_cnt++; if (term_cnt2 !== 2'd3) $display("FAIL cnt2_term_cnt got %0d exp 3", term_cnt2); else pass_cnt++;
        total_cnt++; if (out_valid2 !== 1'b1) $display("FAIL cnt2_valid got %0d exp 1", out_valid2); else pass_cnt++;
        total_cnt++; if (term_cnt !== 4'd5) $display("FAIL cnt4_term_cnt got %0d exp 5", term_cnt); else pass_cnt++;
        step();
    endtask

    initial begin
        test_reset();
        test_pair_add();
        test_accumulate();
        test_saturation();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_sum();
        test_cnt_saturation();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
